// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter: shares one memory port between a fetch and a data requester
// using round-robin arbitration and a per-access wait timeout.  Rev 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IF_ACC = 2'd1,
    S_D_ACC  = 2'd2
  } state_t;

  localparam logic       GNT_IF      = 1'b0;
  localparam logic       GNT_D       = 1'b1;
  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_t     state;
  logic       last_gnt;
  logic [3:0] wait_cnt;

  logic if_elig;
  logic d_elig;
  logic grant_if;
  logic grant_d;
  logic acc_end;

  // A port whose done pulse is showing cannot be re-granted in that cycle.
  always_comb begin
    if_elig  = if_req && !if_done;
    d_elig   = d_req && !d_done;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state == S_IDLE) begin
      if (if_elig && d_elig) begin
        grant_if = (last_gnt == GNT_D);
        grant_d  = (last_gnt == GNT_IF);
      end else begin
        grant_if = if_elig;
        grant_d  = d_elig;
      end
    end
    acc_end = mem_ready || (wait_cnt == TIMEOUT_CNT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      last_gnt  <= GNT_D;
      wait_cnt  <= 4'd0;
      if_done   <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      if_done <= 1'b0;
      if_err  <= 1'b0;
      d_done  <= 1'b0;
      d_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_if) begin
            state     <= S_IF_ACC;
            last_gnt  <= GNT_IF;
            wait_cnt  <= 4'd0;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            busy      <= 1'b1;
          end else if (grant_d) begin
            state     <= S_D_ACC;
            last_gnt  <= GNT_D;
            wait_cnt  <= 4'd0;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            busy      <= 1'b1;
          end
        end
        S_IF_ACC, S_D_ACC: begin
          // mem_ready takes priority over the timeout when both land together.
          if (acc_end) begin
            state  <= S_IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            busy   <= 1'b0;
            if (state == S_IF_ACC) begin
              if_done <= 1'b1;
              if_err  <= !mem_ready;
              if (mem_ready) begin
                if_rdata <= mem_rdata;
              end
            end else begin
              d_done <= 1'b1;
              d_err  <= !mem_ready;
              if (mem_ready && !mem_we) begin
                d_rdata <= mem_rdata;
              end
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: begin
          state  <= S_IDLE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter
// against a transaction-level model of grants, latencies and results.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic          if_err;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic          d_err;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          cycles;
    bit          stable;
    int          first;
    int          last;
  } rec_t;

  rec_t recs[$];
  rec_t cur;
  bit   in_run = 0;
  int   cyc = 0;
  int   n_if_done = 0, n_d_done = 0, idle_busy = 0, run_busy_bad = 0;
  int   exp_if_done = 0, exp_d_done = 0;

  int          if_waits = 0, d_waits = 0, k = 0;
  logic [31:0] if_resp = 0, d_resp = 0;

  logic [31:0] m_if_rdata = 0, m_d_rdata = 0;
  bit          m_last_d = 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int acc_cycles(input int w);
    return (w > TO) ? TO + 1 : w + 1;
  endfunction

  // Bus monitor: collapses each mem_en run into one access record.
  always @(negedge clk) begin
    cyc++;
    if (mem_en === 1'b1) begin
      if (!in_run) begin
        in_run = 1;
        cur.addr = mem_addr; cur.we = mem_we; cur.wdata = mem_wdata;
        cur.cycles = 1; cur.stable = 1; cur.first = cyc;
      end else begin
        cur.cycles++;
        if (mem_addr !== cur.addr || mem_we !== cur.we || mem_wdata !== cur.wdata) cur.stable = 0;
      end
      cur.last = cyc;
      if (busy !== 1'b1) run_busy_bad++;
    end else begin
      if (in_run) begin
        in_run = 0;
        recs.push_back(cur);
      end
      if (busy !== 1'b0) idle_busy++;
    end
    if (if_done === 1'b1) n_if_done++;
    if (d_done === 1'b1) n_d_done++;
  end

  // Memory responder: ready after the planned number of wait cycles, random ready when idle.
  always @(negedge clk) begin
    bit is_d;
    if (mem_en === 1'b1) begin
      is_d      = (if_req && d_req) ? mem_addr[31] : d_req;
      mem_ready = (k == (is_d ? d_waits : if_waits));
      mem_rdata = is_d ? d_resp : if_resp;
      k++;
    end else begin
      k         = 0;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  end

  task automatic do_fetch(input logic [31:0] addr, input int w, input logic [31:0] resp,
                          input bit hold, output int lat);
    bit err, seen;
    if_waits = w; if_resp = resp;
    err = (w > TO);
    if (!err) m_if_rdata = resp;
    exp_if_done++;
    if_req = 1'b1; if_addr = addr;
    lat = 0; seen = 0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      lat = i;
      if (if_done === 1'b1) seen = 1;
    end
    chk("if_done_seen", seen, 1);
    chk("if_err", if_err, err);
    chk("if_rdata", if_rdata, m_if_rdata);
    if (hold) begin
      @(negedge clk); chk("if_done_pulse", if_done, 0); if_req = 1'b0;
    end else begin
      if_req = 1'b0; @(negedge clk); chk("if_done_pulse", if_done, 0);
    end
  endtask

  task automatic do_data(input logic [31:0] addr, input bit we, input logic [31:0] wd, input int w,
                         input logic [31:0] resp, input bit hold, output int lat);
    bit err, seen;
    d_waits = w; d_resp = resp;
    err = (w > TO);
    if (!err && !we) m_d_rdata = resp;
    exp_d_done++;
    d_req = 1'b1; d_addr = addr; d_we = we; d_wdata = wd;
    lat = 0; seen = 0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      lat = i;
      if (d_done === 1'b1) seen = 1;
    end
    chk("d_done_seen", seen, 1);
    chk("d_err", d_err, err);
    chk("d_rdata", d_rdata, m_d_rdata);
    if (hold) begin
      @(negedge clk); chk("d_done_pulse", d_done, 0); d_req = 1'b0;
    end else begin
      d_req = 1'b0; @(negedge clk); chk("d_done_pulse", d_done, 0);
    end
  endtask

  task automatic exp_rec(input logic [31:0] addr, input bit we, input logic [31:0] wd, input int cycles,
                         input string tag, output int first, output int last);
    rec_t r;
    first = 0; last = 0;
    chk({tag, "_rec_present"}, recs.size() > 0, 1);
    if (recs.size() > 0) begin
      r = recs.pop_front();
      chk({tag, "_addr"}, r.addr, addr);
      chk({tag, "_we"}, r.we, we);
      chk({tag, "_cycles"}, r.cycles, cycles);
      chk({tag, "_stable"}, r.stable, 1);
      if (we) chk({tag, "_wdata"}, r.wdata, wd);
      first = r.first; last = r.last;
    end
  endtask

  // mode 0: fetch only, 1: data only, 2: both requested in the same cycle.
  task automatic run_step(input int mode, input logic [31:0] ia, input int iw, input logic [31:0] ir,
                          input bit ih, input logic [31:0] da, input bit dwe, input logic [31:0] dwd,
                          input int dw, input logic [31:0] dr, input bit dh, input string tag);
    int li, ld, f0, l0, f1, l1;
    bit if_first;
    if (mode == 0) begin
      do_fetch(ia, iw, ir, ih, li);
      m_last_d = 0;
      chk({tag, "_lat"}, li, acc_cycles(iw) + 1);
      exp_rec(ia, 0, 0, acc_cycles(iw), tag, f0, l0);
    end else if (mode == 1) begin
      do_data(da, dwe, dwd, dw, dr, dh, ld);
      m_last_d = 1;
      chk({tag, "_lat"}, ld, acc_cycles(dw) + 1);
      exp_rec(da, dwe, dwd, acc_cycles(dw), tag, f0, l0);
    end else begin
      if_first = m_last_d;
      fork
        do_fetch(ia, iw, ir, ih, li);
        do_data(da, dwe, dwd, dw, dr, dh, ld);
      join
      m_last_d = if_first;
      if (if_first) begin
        exp_rec(ia, 0, 0, acc_cycles(iw), {tag, "_1st"}, f0, l0);
        exp_rec(da, dwe, dwd, acc_cycles(dw), {tag, "_2nd"}, f1, l1);
      end else begin
        exp_rec(da, dwe, dwd, acc_cycles(dw), {tag, "_1st"}, f0, l0);
        exp_rec(ia, 0, 0, acc_cycles(iw), {tag, "_2nd"}, f1, l1);
      end
      chk({tag, "_gap"}, f1 - l0, 2);
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int m, f0, l0;
    logic [31:0] ia, da;
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_if_done", if_done, 0);   chk("rst_d_done", d_done, 0);
    chk("rst_if_err", if_err, 0);     chk("rst_d_err", d_err, 0);
    chk("rst_mem_en", mem_en, 0);     chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);         chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_step(0, 32'h0000_0100, 0, 32'h00A0_0093, 0, 0, 0, 0, 0, 0, 0, "fetch_min");
    run_step(2, 32'h0000_0200, 1, 32'h1111_2222, 0, 32'h8000_0300, 0, 0, 1, 32'h3333_4444, 0, "rr_a");
    run_step(0, 32'h0000_0210, 1, 32'h5555_6666, 1, 0, 0, 0, 0, 0, 0, "rr_fetch");
    run_step(2, 32'h0000_0220, 1, 32'h7777_8888, 1, 32'h8000_0310, 0, 0, 1, 32'h9999_AAAA, 1, "rr_b");
    run_step(1, 0, 0, 0, 0, 32'h0000_2004, 1, 32'hDEAD_BEEF, 3, 32'hCAFE_0000, 0, "store");
    run_step(1, 0, 0, 0, 0, 32'h0000_3000, 0, 0, TO + 5, 32'h1234_5678, 0, "load_timeout");
    run_step(1, 0, 0, 0, 0, 32'h0000_3004, 0, 0, TO, 32'h0BAD_F00D, 0, "load_at_limit");

    // Reset during the second wait cycle of a fetch.
    if_waits = 10; if_resp = 32'h5555_0000; if_req = 1'b1; if_addr = 32'h0000_0400;
    @(negedge clk);
    chk("rstmid_mem_en_before", mem_en, 1);
    @(negedge clk);
    rst_n = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("rstmid_mem_en", mem_en, 0);   chk("rstmid_busy", busy, 0);
    chk("rstmid_if_done", if_done, 0); chk("rstmid_if_err", if_err, 0);
    chk("rstmid_mem_we", mem_we, 0);   chk("rstmid_mem_addr", mem_addr, 0);
    chk("rstmid_if_rdata", if_rdata, 0); chk("rstmid_d_rdata", d_rdata, 0);
    m_if_rdata = 0; m_d_rdata = 0; m_last_d = 1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_no_done", if_done, 0);
    exp_rec(32'h0000_0400, 0, 0, 2, "rstmid", f0, l0);

    for (int i = 0; i < 40; i++) begin
      m  = $urandom_range(0, 2);
      ia = {1'b0, 29'($urandom), 2'b00};
      da = {1'b1, 29'($urandom), 2'b00};
      run_step(m, ia, $urandom_range(0, TO + 2), $urandom, 1'($urandom_range(0, 1)),
               da, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, TO + 2), $urandom,
               1'($urandom_range(0, 1)), "rand");
    end

    repeat (2) @(negedge clk);
    chk("if_done_count", n_if_done, exp_if_done);
    chk("d_done_count", n_d_done, exp_d_done);
    chk("busy_when_idle", idle_busy, 0);
    chk("busy_in_access", run_busy_bad, 0);
    chk("no_extra_access", recs.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 15, maximum wait cycles per access before abort (1..15).
REQ-002 Clocking and reset: one clock; reset is synchronous and active-low.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, synchronous active-low reset.
- if_req, in, 1, fetch request; held until if_done.
- if_addr, in, ADDR_W, fetch address.
- if_done, out, 1, one-cycle fetch completion pulse.
- if_err, out, 1, fetch timed out; valid with if_done.
- if_rdata, out, DATA_W, fetched word.
- d_req, in, 1, data request; held until d_done.
- d_we, in, 1, 1 = store, 0 = load.
- d_addr, in, ADDR_W, data address.
- d_wdata, in, DATA_W, store data.
- d_done, out, 1, one-cycle data completion pulse.
- d_err, out, 1, data access timed out; valid with d_done.
- d_rdata, out, DATA_W, load result.
- mem_en, out, 1, memory access active.
- mem_we, out, 1, memory write strobe.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, memory read data.
- mem_ready, in, 1, memory completes the access this cycle.
- busy, out, 1, high when state is not IDLE.

Function
REQ-004 FSM states: IDLE, IF_ACC, D_ACC. One access is in flight at a time.
REQ-005 IDLE, only one of if_req/d_req high: enter the matching ACC state on the next edge.
REQ-006 IDLE, both high: grant the port not granted last (round-robin via last_gnt register); last_gnt updates on every grant.
REQ-007 Grant edge: register addr, we (fetch: 0) and wdata; mem_addr, mem_we and mem_wdata drive from these registers only and stay stable through the access.
REQ-008 mem_en = 1 exactly while in IF_ACC or D_ACC; mem_we = latched we while in D_ACC, else 0.
REQ-009 ACC state with mem_ready = 1 at an edge: capture mem_rdata into if_rdata (fetch) or d_rdata (loads only), return to IDLE, and assert the port's done for exactly the next cycle with err = 0.
REQ-010 Minimum latency: req sampled in IDLE at cycle N; mem_en in cycle N+1; with mem_ready in N+1, done in cycle N+2.
REQ-011 Wait counter: 4 bits; cleared on ACC entry; increments each ACC cycle with mem_ready = 0.
REQ-012 Timeout: when the counter equals TIMEOUT and mem_ready = 0, abort. Return to IDLE, pulse the port's done with err = 1, and leave rdata unchanged.
REQ-013 Completion and timeout in the same cycle: mem_ready wins (normal completion, err = 0).
REQ-014 In the cycle a port's done is high, that port's req is ignored; the requester drops req, or a new request is taken from the following cycle.
REQ-015 A new grant may be issued in the done cycle for the other port's pending req (back-to-back accesses with no idle gap).
REQ-016 mem_ready outside ACC states is ignored.
REQ-017 Stores: d_rdata holds its previous value; d_done pulses on completion.
REQ-018 if_rdata and d_rdata hold their last captured value until the next successful read on the same port.
REQ-019 busy = 1 in IF_ACC and D_ACC, else 0.

Reset
REQ-020 rst_n = 0 at an edge: state IDLE, last_gnt = DATA (first contention goes to fetch), counter 0.
REQ-021 Reset values: if_done, d_done, if_err, d_err, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0.
REQ-022 Reset mid-access aborts silently: no done pulse; mem_en is 0 from the cycle after the reset edge.

Verification
REQ-023 Fetch only: if_addr=0x100, mem_ready=1 in the first ACC cycle, mem_rdata=0x00A00093. Required: mem_en=1 for one cycle, then if_done=1, if_err=0, if_rdata=0x00A00093.
REQ-024 Both requests after reset, 2-cycle memory each. Required: fetch served first, data served next with no idle gap, last_gnt alternates.
REQ-025 Store: d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, ready after 3 waits. Required: mem_we=1 for 4 cycles with address/data stable, then d_done=1 and d_rdata unchanged.
REQ-026 mem_ready never asserted on a load. Required: mem_en high for TIMEOUT+1 cycles, then d_done=1, d_err=1, d_rdata unchanged.
REQ-027 rst_n low during the 2nd wait cycle of a fetch. Required: no if_done, mem_en=0 and busy=0 after the reset edge, all outputs at reset values.
REQ-028 mem_ready=1 exactly when the counter reaches TIMEOUT. Required: normal completion with err=0 and rdata captured.
